// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: IF/ID latch, redirect/flush generation, predictor
// update port with 2-bit hysteresis behind a shadow tag table, and branch statistics.
module branch_resolve_unit #(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_4_out,
    input  logic [31:0]      if_bpu_pc,
    input  logic [IDX_W-1:0] if_bpu_index,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic [31:0]      id_branch_target,
    output logic [1:0]       id_bpu_wen,
    output logic [31:0]      if_new_pc,
    output logic [31:0]      id_pc_4_out,
    output logic [IDX_W-1:0] id_bpu_index,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic        id_valid;
    logic [31:0] pred_pc;

    logic [1:0]  hcnt      [ENTRIES];
    logic [31:0] tag_tbl   [ENTRIES];
    logic        tag_valid [ENTRIES];

    logic        pred_taken;
    logic [31:0] actual_next;
    logic        is_branch;
    logic        is_alias;
    logic        tag_hit;
    logic [1:0]  cur_cnt;
    logic [1:0]  next_cnt;

    always_comb begin
        pred_taken  = (pred_pc != id_pc_4_out);
        actual_next = id_branch_taken ? id_branch_target : id_pc_4_out;
        is_branch   = id_valid & id_is_branch;
        is_alias    = id_valid & ~id_is_branch & pred_taken;
        cur_cnt     = hcnt[id_bpu_index];
        tag_hit     = tag_valid[id_bpu_index] && (tag_tbl[id_bpu_index] == id_pc_4_out);

        // A tag miss re-seeds the counter weakly toward the observed direction.
        next_cnt = id_branch_taken ? 2'b10 : 2'b01;
        if (tag_hit) begin
            if (id_branch_taken)
                next_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
            else
                next_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
        end

        id_bpu_wen    = 2'b00;
        if_new_pc     = 32'h0;
        redirect_o    = 1'b0;
        redirect_pc_o = id_pc_4_out;
        if (is_branch) begin
            id_bpu_wen    = {1'b1, next_cnt[1]};
            if_new_pc     = id_branch_target;
            redirect_o    = (actual_next != pred_pc);
            redirect_pc_o = actual_next;
        end else if (is_alias) begin
            id_bpu_wen    = 2'b10;
            if_new_pc     = id_pc_4_out;
            redirect_o    = 1'b1;
            redirect_pc_o = id_pc_4_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid       <= 1'b0;
            id_pc_4_out    <= 32'h0;
            id_bpu_index   <= '0;
            pred_pc        <= 32'h0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                hcnt[i]      <= 2'b01;
                tag_tbl[i]   <= 32'h0;
                tag_valid[i] <= 1'b0;
            end
        end else if (!pause_i) begin
            id_valid     <= if_valid_i & ~redirect_o;
            id_pc_4_out  <= if_pc_4_out;
            id_bpu_index <= if_bpu_index;
            pred_pc      <= if_bpu_pc;

            if (is_branch) begin
                hcnt[id_bpu_index] <= next_cnt;
                if (!tag_hit) begin
                    tag_tbl[id_bpu_index]   <= id_pc_4_out;
                    tag_valid[id_bpu_index] <= 1'b1;
                end
                branch_cnt <= branch_cnt + CNT_W'(1);
            end else if (is_alias) begin
                hcnt[id_bpu_index]      <= 2'b00;
                tag_valid[id_bpu_index] <= 1'b0;
            end

            if (redirect_o)
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected update/redirect responses are
// queued by the stimulus and consumed by an independent output monitor.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pause_i;
    logic        if_valid_i;
    logic [31:0] if_pc_4_out;
    logic [31:0] if_bpu_pc;
    logic [4:0]  if_bpu_index;
    logic        id_is_branch;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic [1:0]  id_bpu_wen;
    logic [31:0] if_new_pc;
    logic [31:0] id_pc_4_out;
    logic [4:0]  id_bpu_index;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    branch_resolve_unit #(.ENTRIES(32), .IDX_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pause_i(pause_i), .if_valid_i(if_valid_i),
        .if_pc_4_out(if_pc_4_out), .if_bpu_pc(if_bpu_pc), .if_bpu_index(if_bpu_index),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_branch_target(id_branch_target), .id_bpu_wen(id_bpu_wen), .if_new_pc(if_new_pc),
        .id_pc_4_out(id_pc_4_out), .id_bpu_index(id_bpu_index), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  wen;
        logic [31:0] npc;
        logic [4:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && !pause_i && (redirect_o || id_bpu_wen[1])) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: redirect=%0b wen=%b with no queued expectation",
                         redirect_o, id_bpu_wen);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                check("mon_redirect", 32'(redirect_o), 32'(e.redir));
                check("mon_redirect_pc", redirect_pc_o, e.rpc);
                check("mon_wen", 32'(id_bpu_wen), 32'(e.wen));
                check("mon_new_pc", if_new_pc, e.npc);
                check("mon_index", 32'(id_bpu_index), 32'(e.idx));
            end
        end
    end

    // One instruction: an IF cycle, then its ID cycle (optionally paused).
    task automatic do_insn(input logic [31:0] pc4, input logic [31:0] ppc, input logic [4:0] idx,
                           input logic is_br, input logic taken, input logic [31:0] tgt,
                           input logic e_redir, input logic [31:0] e_rpc, input logic [1:0] e_wen,
                           input logic [31:0] e_npc, input int npause, input logic fetch_same);
        exp_t e;
        int   held_mis;
        @(posedge clk); #1;
        if_valid_i = 1'b1; if_pc_4_out = pc4; if_bpu_pc = ppc; if_bpu_index = idx;
        id_is_branch = 1'b0;
        @(posedge clk); #1;
        if_valid_i = fetch_same;
        if_pc_4_out = 32'h900; if_bpu_pc = 32'h990; if_bpu_index = 5'd9;
        id_is_branch = is_br; id_branch_taken = taken; id_branch_target = tgt;
        if (e_redir || e_wen[1]) begin
            e = '{redir: e_redir, rpc: e_rpc, wen: e_wen, npc: e_npc, idx: idx};
            exp_q.push_back(e);
            pushed++;
        end
        if (is_br) exp_br++;
        if (e_redir) exp_mis++;
        held_mis = mispredict_cnt;
        if (npause > 0) begin
            pause_i = 1'b1;
            repeat (npause) begin
                @(negedge clk);
                check("pause_redirect_held", 32'(redirect_o), 32'(e_redir));
                check("pause_wen_held", 32'(id_bpu_wen), 32'(e_wen));
                check("pause_mis_frozen", 32'(mispredict_cnt), 32'(held_mis));
                @(posedge clk); #1;
            end
            pause_i = 1'b0;
        end
        @(posedge clk); #1;
        if_valid_i = 1'b0; id_is_branch = 1'b0;
        check("branch_cnt", 32'(branch_cnt), 32'(exp_br));
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(exp_mis));
        if (fetch_same) begin
            @(negedge clk);
            check("squash_redirect", 32'(redirect_o), 32'h0);
            check("squash_wen", 32'(id_bpu_wen), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pause_i = 1'b0; if_valid_i = 1'b0;
        if_pc_4_out = 32'h0; if_bpu_pc = 32'h0; if_bpu_index = 5'd0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0; id_branch_target = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_redirect", 32'(redirect_o), 32'h0);
        check("rst_wen", 32'(id_bpu_wen), 32'h0);
        check("rst_pc4", id_pc_4_out, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_redirect_pc", redirect_pc_o, 32'h0);
        check("post_rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("post_rst_index", 32'(id_bpu_index), 32'h0);

        // pc4, pred, idx, br, taken, target | redirect, rpc, wen, new_pc | pause, fetch_same
        do_insn(32'h104, 32'h104, 5'd3, 1, 1, 32'h200, 1, 32'h200, 2'b11, 32'h200, 0, 1);
        do_insn(32'h104, 32'h200, 5'd3, 1, 0, 32'h200, 1, 32'h104, 2'b10, 32'h200, 0, 0);
        do_insn(32'h104, 32'h200, 5'd3, 1, 0, 32'h200, 1, 32'h104, 2'b10, 32'h200, 0, 0);
        do_insn(32'h104, 32'h200, 5'd3, 1, 1, 32'h200, 0, 32'h200, 2'b10, 32'h200, 0, 0);
        do_insn(32'h104, 32'h200, 5'd3, 1, 1, 32'h200, 0, 32'h200, 2'b11, 32'h200, 0, 0);
        do_insn(32'h300, 32'h500, 5'd7, 0, 0, 32'h0,   1, 32'h300, 2'b10, 32'h300, 0, 0);
        do_insn(32'h400, 32'h400, 5'd2, 0, 0, 32'h0,   0, 32'h400, 2'b00, 32'h0,   0, 0);
        // Paused mispredict: counter 10 -> 01 exactly once.
        do_insn(32'h104, 32'h200, 5'd3, 1, 0, 32'h200, 1, 32'h104, 2'b10, 32'h200, 4, 0);
        // From 01 a taken hit crosses to 10 (a repeated paused update would have left 00 -> 01).
        do_insn(32'h104, 32'h104, 5'd3, 1, 1, 32'h200, 1, 32'h200, 2'b11, 32'h200, 0, 0);
        // Branch on idx 7 after the alias: tag cleared, so it seeds 01 on not-taken.
        do_insn(32'h300, 32'h300, 5'd7, 1, 0, 32'h380, 0, 32'h300, 2'b10, 32'h380, 0, 0);

        // Reset in the middle of a pending alias update.
        @(posedge clk); #1;
        if_valid_i = 1'b1; if_pc_4_out = 32'h600; if_bpu_pc = 32'h700; if_bpu_index = 5'd1;
        @(posedge clk); #1;
        if_valid_i = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_redirect", 32'(redirect_o), 32'h0);
        check("midrst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("midrst_mis_cnt", 32'(mispredict_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_midrst_wen", 32'(id_bpu_wen), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("pop_count", 32'(popped), 32'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
